// File: rtl/easyaxi_rd_mst_if.sv
// AXI read address (AR) and read data (R) channels between a read master and its slave.
interface easyaxi_rd_mst_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [SIZE_W-1:0] arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/easyaxi_rd_mst.sv
// AXI read master, one burst outstanding: AR issued the cycle after command accept.
// R beats pass through combinationally to the user port; usr_dready drives rready directly.
module easyaxi_rd_mst #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [SIZE_W-1:0] cmd_size,
  input  logic [1:0]        cmd_burst,
  easyaxi_rd_mst_if.master  axi_mst,
  output logic              usr_dvalid,
  input  logic              usr_dready,
  output logic [DATA_W-1:0] usr_data,
  output logic              usr_dlast,
  output logic              done,
  output logic [5:0]        sts
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, AR_REQ, R_WAIT, DONE} state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [1:0]        burst;
  } cmd_t;

  state_t            state, state_nxt;
  cmd_t              cmd_q;
  logic [LEN_W:0]    beat_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [5:0]        sts_q;

  logic              cmd_hs, ar_hs, r_hs, last_beat;
  logic [31:0]       span, end_off, lsb_mask;
  logic              bad_burst, bad_size, bad_wrap_len, bad_wrap_align, bad_4k, cmd_illegal;

  // Legality is judged on the live payload so the decision is ready at the accept edge.
  always_comb begin
    span           = (32'(cmd_len) + 32'd1) << cmd_size;
    end_off        = 32'(cmd_addr[11:0]) + span;
    lsb_mask       = (32'd1 << cmd_size) - 32'd1;
    bad_burst      = (cmd_burst == 2'b11);
    bad_size       = (32'(cmd_size) > 32'(MAX_SIZE));
    bad_wrap_len   = (cmd_burst == 2'b10) &&
                     !(32'(cmd_len) inside {32'd1, 32'd3, 32'd7, 32'd15});
    bad_wrap_align = (cmd_burst == 2'b10) && ((32'(cmd_addr) & lsb_mask) != 32'd0);
    bad_4k         = (cmd_burst != 2'b00) && (end_off > 32'd4096);
    cmd_illegal    = bad_burst | bad_size | bad_wrap_len | bad_wrap_align | bad_4k;
  end

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign ar_hs     = axi_mst.arvalid & axi_mst.arready;
  assign r_hs      = axi_mst.rvalid & axi_mst.rready;
  assign last_beat = (beat_cnt == {1'b0, cmd_q.len});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_hs) state_nxt = cmd_illegal ? DONE : AR_REQ;
      AR_REQ:  if (ar_hs) state_nxt = R_WAIT;
      R_WAIT:  if (r_hs && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = 1'b0;
    axi_mst.arvalid = 1'b0;
    axi_mst.rready = 1'b0;
    usr_dvalid     = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE:   cmd_ready = enable;
      AR_REQ: axi_mst.arvalid = 1'b1;
      R_WAIT: begin
        axi_mst.rready = usr_dready;
        usr_dvalid     = axi_mst.rvalid;
      end
      DONE:   done = 1'b1;
      default: ;
    endcase
  end

  assign axi_mst.arid    = cmd_q.id;
  assign axi_mst.araddr  = cmd_q.addr;
  assign axi_mst.arlen   = cmd_q.len;
  assign axi_mst.arsize  = cmd_q.size;
  assign axi_mst.arburst = cmd_q.burst;
  assign usr_data        = axi_mst.rdata;
  assign usr_dlast       = (state == R_WAIT) && last_beat;
  assign sts             = sts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      beat_cnt <= '0;
      to_cnt   <= '0;
      sts_q    <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_hs) begin
          cmd_q    <= '{id: cmd_id, addr: cmd_addr, len: cmd_len, size: cmd_size, burst: cmd_burst};
          sts_q    <= {1'b0, cmd_illegal, 4'b0000};
          beat_cnt <= '0;
          to_cnt   <= '0;
        end
        AR_REQ, R_WAIT: begin
          if (ar_hs || r_hs)                to_cnt <= '0;
          else if (to_cnt != {TO_W{1'b1}})  to_cnt <= to_cnt + TO_W'(1);
          if (to_cnt == {TO_W{1'b1}})       sts_q[5] <= 1'b1;
          if (ar_hs) beat_cnt <= '0;
          // Beat count, not rlast, ends the burst; an rlast disagreement is only flagged.
          if (r_hs) begin
            beat_cnt <= beat_cnt + (LEN_W + 1)'(1);
            if (axi_mst.rid != cmd_q.id)   sts_q[3] <= 1'b1;
            if (axi_mst.rresp == 2'b10)    sts_q[0] <= 1'b1;
            if (axi_mst.rresp == 2'b11)    sts_q[1] <= 1'b1;
            if (axi_mst.rlast != last_beat) sts_q[2] <= 1'b1;
          end
        end
        DONE:    sts_q <= '0;
        default: ;
      endcase
    end
  end

endmodule
